// File: rtl/riscv_pkg.sv
// Shared definitions for the boot loader: word geometry and the loader state encoding.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    HDR0,
    HDR1,
    DATA,
    HOLD,
    RUN,
    ERR
  } boot_state_t;
endpackage

// File: rtl/byte_packer.sv
// Packs a little-endian byte stream into XLEN-bit words; word_valid pulses the cycle
// after the last byte of each word is accepted.
module byte_packer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [7:0]      in_byte,
  input  logic            clear,
  output logic [XLEN-1:0] word,
  output logic            word_valid,
  output logic            last_lane
);

  logic [LANE_W-1:0] idx_q, idx_d;
  logic [XLEN-1:0]   lanes_q, lanes_d;
  logic [XLEN-1:0]   word_q, word_d;
  logic              word_valid_q, word_valid_d;

  generate
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign lanes_d[gi*8 +: 8] = (in_valid && idx_q == LANE_W'(gi)) ? in_byte
                                                                      : lanes_q[gi*8 +: 8];
    end
  endgenerate

  assign last_lane = (idx_q == LANE_W'(WORD_BYTES - 1));

  always_comb begin
    idx_d        = idx_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clear) begin
      idx_d = '0;
    end else if (in_valid) begin
      idx_d = idx_q + LANE_W'(1);
      if (last_lane) begin
        word_d       = lanes_d;
        word_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q        <= '0;
      lanes_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      lanes_q      <= lanes_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed byte stream into instruction memory and holds the core in
// reset until the program is in place plus HOLD_CYCLES of settling.
module imem_boot_loader
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int NUM_WORDS   = 256,
  parameter int HOLD_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [XLEN-1:0]   imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              err
);

  boot_state_t     state_q, state_d;
  logic [7:0]      n_lo_q, n_lo_d;
  logic [15:0]     n_q, n_d;
  logic [ADDR_W:0] widx_q, widx_d;
  logic [7:0]      hold_q, hold_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  logic        xfer;
  logic [15:0] hdr_n;
  logic        pack_valid;
  logic        pack_clear;
  logic        last_lane;
  logic        word_last;

  assign s_ready    = !reset && (state_q inside {HDR0, HDR1, DATA});
  assign xfer       = s_valid && s_ready;
  assign hdr_n      = {s_data, n_lo_q};
  assign pack_valid = xfer && (state_q == DATA);
  assign pack_clear = (state_q != DATA);
  // widx_q counts completed writes, so it equals the index of the word being assembled.
  assign word_last  = (16'(widx_q) == n_q - 16'd1);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (pack_valid),
    .in_byte    (s_data),
    .clear      (pack_clear),
    .word       (imem_wdata),
    .word_valid (imem_we),
    .last_lane  (last_lane)
  );

  always_comb begin
    state_d = state_q;
    n_lo_d  = n_lo_q;
    n_d     = n_q;
    hold_d  = hold_q;
    widx_d  = imem_we ? widx_q + (ADDR_W+1)'(1) : widx_q;
    case (state_q)
      HDR0: begin
        if (xfer) begin
          n_lo_d  = s_data;
          state_d = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_d = hdr_n;
          if (hdr_n == 16'd0)                 state_d = HOLD;
          else if (hdr_n > 16'(NUM_WORDS))    state_d = ERR;
          else                                state_d = DATA;
        end
      end
      DATA: begin
        if (pack_valid && last_lane && word_last) state_d = HOLD;
      end
      HOLD: begin
        // The final write lands in the first HOLD cycle, so counting from entry gives
        // exactly HOLD_CYCLES cycles between that write and release.
        hold_d = hold_q + 8'd1;
        if (hold_q == 8'(HOLD_CYCLES - 1)) state_d = RUN;
      end
      RUN, ERR: ;
      default: state_d = HDR0;
    endcase
    cpu_reset_d = (state_d != RUN);
    done_d      = (state_d == RUN);
    err_d       = (state_d == ERR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR0;
      n_lo_q      <= '0;
      n_q         <= '0;
      widx_q      <= '0;
      hold_q      <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_lo_q      <= n_lo_d;
      n_q         <= n_d;
      widx_q      <= widx_d;
      hold_q      <= hold_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign imem_addr = widx_q[ADDR_W-1:0];
  assign cpu_reset = cpu_reset_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: stream loads, gaps, empty/overflow headers, resets.
module tb_imem_boot_loader;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  imem_boot_loader #(.ADDR_W(8), .NUM_WORDS(256), .HOLD_CYCLES(HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];
  logic [7:0]  stream[$];
  logic [7:0]  exp_a[$];
  logic [31:0] exp_d[$];
  int          last_we_cyc = -1;
  int          fall_cyc = -1;
  int          last_hs = -1;
  logic        cr_prev = 1'b1;

  // Write/cpu_reset monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (imem_we) begin
        wa_q.push_back(imem_addr);
        wd_q.push_back(imem_wdata);
        last_we_cyc = cyc;
        $display("  write addr=%0d data=%08h cyc=%0d", imem_addr, imem_wdata, cyc);
      end
      if (cr_prev && !cpu_reset) fall_cyc = cyc;
      cr_prev = cpu_reset;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic clear_mon();
    wa_q.delete();
    wd_q.delete();
    exp_a.delete();
    exp_d.delete();
    fall_cyc    = -1;
    last_we_cyc = -1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit hs = 1'b0;
    int n  = 0;
    while (!hs && n < 200) begin
      @(negedge clk);
      n++;
      if (gaps && $urandom_range(1) == 0) begin
        s_valid = 1'b0;
        s_data  = 8'($urandom);
      end else begin
        s_valid = 1'b1;
        s_data  = b;
        hs      = s_ready;
        if (hs) last_hs = cyc + 1;
      end
      @(posedge clk);
    end
    if (!hs) check("send_timeout", 32'(hs), 32'd1);
  endtask

  task automatic send_stream(input bit gaps);
    foreach (stream[i]) send_byte(stream[i], gaps);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    #1;
    check("done", 32'(done), 32'd1);
    check("cpu_reset_low", 32'(cpu_reset), 32'd0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(exp_a.size()));
    foreach (exp_a[i]) begin
      check({tag, "_addr"}, (i < wa_q.size()) ? 32'(wa_q[i]) : 32'hFFFF_FFFF, 32'(exp_a[i]));
      check({tag, "_data"}, (i < wd_q.size()) ? wd_q[i] : 32'hFFFF_FFFF, exp_d[i]);
    end
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", imem_wdata, 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_release_s_ready", 32'(s_ready), 32'd1);

    // Basic two-word load, no gaps.
    $display("-- basic load");
    clear_mon();
    stream = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    exp_a  = '{8'd0, 8'd1};
    exp_d  = '{32'h0000_0013, 32'h0010_0093};
    send_stream(1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("basic_s_ready_after", 32'(s_ready), 32'd0);
    wait_done();
    check_writes("basic");
    check("basic_hold_gap", 32'(fall_cyc - last_we_cyc), 32'(HOLD));
    check("basic_err", 32'(err), 32'd0);

    // Same stream with random gaps.
    $display("-- backpressure");
    pulse_reset();
    clear_mon();
    exp_a = '{8'd0, 8'd1};
    exp_d = '{32'h0000_0013, 32'h0010_0093};
    send_stream(1'b1);
    @(negedge clk);
    s_valid = 1'b0;
    #1;
    check("gap_s_ready_after", 32'(s_ready), 32'd0);
    wait_done();
    check_writes("gap");
    check("gap_hold_gap", 32'(fall_cyc - last_we_cyc), 32'(HOLD));

    // Empty program.
    $display("-- empty program");
    pulse_reset();
    clear_mon();
    stream = '{8'h00, 8'h00};
    send_stream(1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    wait_done();
    check_writes("empty");
    check("empty_release_cyc", 32'(fall_cyc), 32'(last_hs + HOLD));

    // Overflow: N = 0x0101 > 256.
    $display("-- overflow");
    pulse_reset();
    clear_mon();
    stream = '{8'h01, 8'h01};
    send_stream(1'b0);
    @(negedge clk);
    #1;
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_s_ready", 32'(s_ready), 32'd0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'(i);
      #1;
      if (cpu_reset !== 1'b1 || done !== 1'b0) check("ovf_cpu_reset_held", 32'(cpu_reset), 32'd1);
    end
    check("ovf_cpu_reset_end", 32'(cpu_reset), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    check("ovf_nwrites", 32'(wa_q.size()), 32'd0);

    // Reset during word 1 of a 3-word load, then a 1-word load.
    $display("-- mid-load reset");
    pulse_reset();
    clear_mon();
    stream = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    send_stream(1'b0);
    pulse_reset();
    check("mid_we_after_reset", 32'(imem_we), 32'd0);
    check("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_first_load_writes", 32'(wa_q.size()), 32'd1);
    clear_mon();
    stream = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_a  = '{8'd0};
    exp_d  = '{32'hDEAD_BEEF};
    send_stream(1'b0);
    @(negedge clk);
    s_valid = 1'b0;
    wait_done();
    check_writes("mid");

    // Reset while running.
    $display("-- reset in RUN");
    pulse_reset();
    check("run_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("run_rst_done", 32'(done), 32'd0);
    check("run_rst_s_ready", 32'(s_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
